// File: rtl/zorro2_autoconfig.sv
// ---------------------------------------------------------------------------
// zorro2_autoconfig
//
// Zorro II Autoconfig responder for the SF500 fast RAM. Answers host reads of
// the $E80000 config space with the board's nibble-coded identity and accepts
// the base-address write that places the RAM in the memory map.
//
// Optional feature macro: ZORRO2_SHUTUP_EN
//   defined   : a write to $4C parks the board in SHUTUP (chain passed on,
//               RAM never decoded).
//   undefined : a $4C write is acknowledged and ignored.
//
// Ports
//   CLK              system clock, all state on the rising edge
//   RESET            synchronous, active-high reset
//   A[23:1]          CPU address
//   AS_n, UDS_n      asynchronous bus strobes (synchronised internally)
//   RW_n             1 = read, 0 = write
//   D_IN[3:0]        CPU data D[15:12]
//   CONFIG_IN_n      chain enable, low = this board may configure
//   JP2              size jumper, 1 = 8MB, 0 = 4MB
//   D_OUT[3:0]       nibble driven onto D[15:12]
//   D_OE             data-bus drive enable
//   DTACK_n          cycle acknowledge for config accesses
//   BASE_RAM[2:0]    assigned base A[23:21]
//   RAM_CONFIGURED_n low once the base has been written
//   CONFIG_OUT_n     chain output to the next board
// ---------------------------------------------------------------------------
module zorro2_autoconfig #(
    parameter logic [15:0] MANUF_ID   = 16'h07DB,
    parameter logic [7:0]  PRODUCT_ID = 8'h01,
    parameter logic [31:0] SERIAL_NO  = 32'h00000001
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:1] A,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        RW_n,
    input  logic [3:0]  D_IN,
    input  logic        CONFIG_IN_n,
    input  logic        JP2,
    output logic [3:0]  D_OUT,
    output logic        D_OE,
    output logic        DTACK_n,
    output logic [2:0]  BASE_RAM,
    output logic        RAM_CONFIGURED_n,
    output logic        CONFIG_OUT_n
);

    typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;
    typedef enum logic [1:0] {CFG_UNCONF, CFG_CONFIGURED, CFG_SHUTUP} cfg_state_t;

    bus_state_t bus_state_q, bus_state_d;
    cfg_state_t cfg_state_q, cfg_state_d;

    logic       as_meta_q, as_s_q, uds_meta_q, uds_s_q;
    logic [3:0] d_out_q, d_out_d;
    logic [2:0] base_q, base_d;
    logic       ram_cfg_n_q, ram_cfg_n_d;
    logic       cfg_out_n_q, cfg_out_n_d;
    logic       wr_done_q, wr_done_d;
    logic       wr_commit;
    logic       hit;
    logic [3:0] nibble;
    logic [15:0] manuf_sh;
    logic [31:0] serial_sh;
    logic [2:0]  serial_k;

    // Address bits outside the decoded window and D[12] carry no information here.
    logic unused_bits;
    assign unused_bits = ^{A[15:8], D_IN[0]};

    assign hit = !as_s_q && (A[23:16] == 8'hE8) && !CONFIG_IN_n
                 && (cfg_state_q == CFG_UNCONF);

    // Identity nibble lookup. The ID fields are stored inverted on the bus,
    // most significant nibble at the lowest offset.
    assign manuf_sh  = MANUF_ID >> {~A[2:1], 2'b00};
    assign serial_k  = A[3:1] - 3'd4;       // word $0C..$13 -> nibble index 0..7
    assign serial_sh = SERIAL_NO >> {~serial_k, 2'b00};

    always_comb begin
        nibble = 4'hF;
        case (A[7:1])
            7'h00:                      nibble = 4'hE;
            7'h01:                      nibble = JP2 ? 4'h0 : 4'h7;
            7'h02:                      nibble = ~PRODUCT_ID[7:4];
            7'h03:                      nibble = ~PRODUCT_ID[3:0];
            7'h04, 7'h05:               nibble = ~4'h0;
            7'h08, 7'h09, 7'h0A, 7'h0B: nibble = ~manuf_sh[3:0];
            7'h0C, 7'h0D, 7'h0E, 7'h0F,
            7'h10, 7'h11, 7'h12, 7'h13: nibble = ~serial_sh[3:0];
            7'h20, 7'h21:               nibble = 4'h0;
            default:                    nibble = 4'hF;
        endcase
    end

    // Bus FSM: acknowledge decoded config cycles and hold until AS_n releases.
    always_comb begin
        bus_state_d = bus_state_q;
        d_out_d     = d_out_q;
        wr_done_d   = wr_done_q;
        wr_commit   = 1'b0;
        DTACK_n     = 1'b1;
        D_OE        = 1'b0;
        case (bus_state_q)
            BUS_IDLE: begin
                wr_done_d = 1'b0;
                if (hit) begin
                    bus_state_d = BUS_ACK;
                    d_out_d     = nibble;
                end
            end
            BUS_ACK: begin
                if (as_s_q) begin
                    // Strobe gone: release the bus in this very cycle.
                    bus_state_d = BUS_IDLE;
                end else begin
                    DTACK_n = 1'b0;
                    D_OE    = RW_n;
                    // A late UDS still commits, but only once per bus cycle.
                    if (!RW_n && !uds_s_q && !wr_done_q) begin
                        wr_commit = 1'b1;
                        wr_done_d = 1'b1;
                    end
                end
            end
            default: bus_state_d = BUS_IDLE;
        endcase
    end

    // Config FSM: UNCONF until the base write (or shut-up); then terminal.
    always_comb begin
        cfg_state_d = cfg_state_q;
        base_d      = base_q;
        ram_cfg_n_d = ram_cfg_n_q;
        cfg_out_n_d = cfg_out_n_q;
        if (wr_commit && cfg_state_q == CFG_UNCONF) begin
            case (A[7:1])
                7'h24: begin
                    // 2MB granularity: D[15:13] carries A23..A21 of the base.
                    base_d      = D_IN[3:1];
                    ram_cfg_n_d = 1'b0;
                    cfg_out_n_d = 1'b0;
                    cfg_state_d = CFG_CONFIGURED;
                end
`ifdef ZORRO2_SHUTUP_EN
                7'h26: begin
                    cfg_out_n_d = 1'b0;
                    cfg_state_d = CFG_SHUTUP;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            as_meta_q   <= 1'b1;
            as_s_q      <= 1'b1;
            uds_meta_q  <= 1'b1;
            uds_s_q     <= 1'b1;
            bus_state_q <= BUS_IDLE;
            cfg_state_q <= CFG_UNCONF;
            d_out_q     <= 4'hF;
            base_q      <= 3'b000;
            ram_cfg_n_q <= 1'b1;
            cfg_out_n_q <= 1'b1;
            wr_done_q   <= 1'b0;
        end else begin
            as_meta_q   <= AS_n;
            as_s_q      <= as_meta_q;
            uds_meta_q  <= UDS_n;
            uds_s_q     <= uds_meta_q;
            bus_state_q <= bus_state_d;
            cfg_state_q <= cfg_state_d;
            d_out_q     <= d_out_d;
            base_q      <= base_d;
            ram_cfg_n_q <= ram_cfg_n_d;
            cfg_out_n_q <= cfg_out_n_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign D_OUT            = d_out_q;
    assign BASE_RAM         = base_q;
    assign RAM_CONFIGURED_n = ram_cfg_n_q;
    assign CONFIG_OUT_n     = cfg_out_n_q;

endmodule
